serial_paralelo_rx: RTL and testbench

Receive-side deserializer at the far end of the PHY link. It takes the one-bit serial stream and performs comma (0xBC) byte alignment. After a run of aligned commas it declares the link active, which is the "active" qualifier consumed by the transmit-side recirculation logic. In the active state it delivers payload bytes in parallel with a one-cycle valid and suppresses idle and comma characters.

---
 rtl/serial_paralelo_rx.sv | 128 ++++++++++++
 tb/tb_serial_paralelo_rx.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/serial_paralelo_rx.sv
// Receive deserializer: comma byte alignment, link activation,
// and payload delivery with idle/comma suppression.
module serial_paralelo_rx #(
  parameter logic [7:0]  COMMA       = 8'hBC,
  parameter logic [7:0]  IDLE        = 8'h7C,
  parameter int unsigned COMMA_COUNT = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       data_in,
  output logic [7:0] data_out,
  output logic       valid_out,
  output logic       byte_strobe,
  output logic       aligned,
  output logic       active
);

  typedef enum logic [1:0] {
    SEARCH,
    ALIGN,
    ACTIVE
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  sr_q;
  logic [7:0]  nxt;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [3:0]  bc_cnt_q, bc_cnt_d;
  logic [7:0]  data_q, data_d;
  logic        valid_q, valid_d;
  logic        strobe_q, strobe_d;
  logic        aligned_q, aligned_d;
  logic        active_q, active_d;
  logic        byte_done;
  logic [4:0]  bc_inc;

  assign nxt       = {sr_q[6:0], data_in};
  assign byte_done = (bit_cnt_q == 3'd7);
  assign bc_inc    = {1'b0, bc_cnt_q} + 5'd1;

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    bc_cnt_d  = bc_cnt_q;
    data_d    = data_q;
    valid_d   = 1'b0;
    strobe_d  = 1'b0;
    aligned_d = aligned_q;
    active_d  = active_q;
    unique case (state_q)
      SEARCH: begin
        if (nxt == COMMA) begin
          bit_cnt_d = 3'd0;
          bc_cnt_d  = 4'd1;
          aligned_d = 1'b1;
          if (COMMA_COUNT == 1) begin
            state_d  = ACTIVE;
            active_d = 1'b1;
          end else begin
            state_d = ALIGN;
          end
        end
      end
      ALIGN: begin
        bit_cnt_d = bit_cnt_q + 3'd1;
        if (byte_done) begin
          bit_cnt_d = 3'd0;
          strobe_d  = 1'b1;
          if (nxt == COMMA) begin
            bc_cnt_d = bc_inc[3:0];
            if (bc_inc == 5'(COMMA_COUNT)) begin
              state_d  = ACTIVE;
              active_d = 1'b1;
            end
          end else begin
            // lock lost; sliding search resumes on the next bit
            bc_cnt_d  = 4'd0;
            aligned_d = 1'b0;
            state_d   = SEARCH;
          end
        end
      end
      ACTIVE: begin
        bit_cnt_d = bit_cnt_q + 3'd1;
        if (byte_done) begin
          bit_cnt_d = 3'd0;
          strobe_d  = 1'b1;
          if (nxt != IDLE && nxt != COMMA) begin
            data_d  = nxt;
            valid_d = 1'b1;
          end
        end
      end
      default: state_d = SEARCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= SEARCH;
      sr_q      <= 8'd0;
      bit_cnt_q <= 3'd0;
      bc_cnt_q  <= 4'd0;
      data_q    <= 8'd0;
      valid_q   <= 1'b0;
      strobe_q  <= 1'b0;
      aligned_q <= 1'b0;
      active_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      sr_q      <= nxt;
      bit_cnt_q <= bit_cnt_d;
      bc_cnt_q  <= bc_cnt_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      strobe_q  <= strobe_d;
      aligned_q <= aligned_d;
      active_q  <= active_d;
    end
  end

  assign data_out    = data_q;
  assign valid_out   = valid_q;
  assign byte_strobe = strobe_q;
  assign aligned     = aligned_q;
  assign active      = active_q;

endmodule

// File: tb/tb_serial_paralelo_rx.sv
// Bench for serial_paralelo_rx: bit-history reference model
// compared every cycle, plus directed literal checkpoints.
module tb_serial_paralelo_rx;

  localparam logic [7:0] BC = 8'hBC;
  localparam logic [7:0] ID = 8'h7C;
  localparam int CC = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       data_in;
  logic [7:0] data_out;
  logic       valid_out;
  logic       byte_strobe;
  logic       aligned;
  logic       active;

  int n_chk = 0;
  int n_fail = 0;

  serial_paralelo_rx #(
    .COMMA(BC),
    .IDLE(ID),
    .COMMA_COUNT(CC)
  ) dut (
    .clk(clk),
    .reset(reset),
    .data_in(data_in),
    .data_out(data_out),
    .valid_out(valid_out),
    .byte_strobe(byte_strobe),
    .aligned(aligned),
    .active(active)
  );

  always #5 clk = ~clk;

  // model: last 8 bits seen, bits since boundary, comma run
  logic [7:0] m_hist;
  logic       m_al, m_act, m_val, m_stb, m_on;
  logic [7:0] m_dout;
  int         m_nb, m_run;

  initial m_on = 1'b0;

  always @(posedge clk) begin
    if (!reset) begin
      m_hist = 8'd0; m_al = 0; m_act = 0;
      m_val = 0; m_stb = 0; m_dout = 8'd0;
      m_nb = 0; m_run = 0; m_on = 1'b1;
    end else if (m_on) begin
      m_hist = {m_hist[6:0], data_in};
      m_val = 0;
      m_stb = 0;
      if (!m_al) begin
        if (m_hist == BC) begin
          m_al = 1; m_nb = 0; m_run = 1;
          if (m_run == CC) m_act = 1;
        end
      end else begin
        m_nb = m_nb + 1;
        if (m_nb == 8) begin
          m_nb = 0;
          m_stb = 1;
          if (m_act) begin
            if (m_hist != ID && m_hist != BC) begin
              m_dout = m_hist;
              m_val = 1;
            end
          end else if (m_hist == BC) begin
            m_run = m_run + 1;
            if (m_run == CC) m_act = 1;
          end else begin
            m_al = 0;
            m_run = 0;
          end
        end
      end
    end
  end

  task automatic chk(input string nm,
                     input logic [7:0] got,
                     input logic [7:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (m_on) begin
      chk("data_out", data_out, m_dout);
      chk("valid_out", {7'd0, valid_out}, {7'd0, m_val});
      chk("byte_strobe", {7'd0, byte_strobe}, {7'd0, m_stb});
      chk("aligned", {7'd0, aligned}, {7'd0, m_al});
      chk("active", {7'd0, active}, {7'd0, m_act});
    end
  end

  task automatic drive(input logic r, input logic b);
    @(negedge clk);
    reset = r;
    data_in = b;
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) drive(1'b1, v[i]);
  endtask

  task automatic after_edge;
    @(posedge clk);
    #1;
  endtask

  task automatic lit(input string nm,
                     input logic [7:0] got,
                     input logic [7:0] exp);
    chk(nm, got, exp);
  endtask

  initial begin
    reset = 1'b0;
    data_in = 1'b0;
    repeat (5) drive(1'b0, 1'($urandom));
    after_edge;
    lit("rst_dout", data_out, 8'h00);
    lit("rst_valid", {7'd0, valid_out}, 8'd0);
    lit("rst_strobe", {7'd0, byte_strobe}, 8'd0);
    lit("rst_aligned", {7'd0, aligned}, 8'd0);
    lit("rst_active", {7'd0, active}, 8'd0);

    repeat (3) drive(1'b1, 1'($urandom));
    send_byte(BC);
    after_edge;
    lit("lock_aligned", {7'd0, aligned}, 8'd1);
    lit("lock_strobe", {7'd0, byte_strobe}, 8'd0);
    lit("lock_active", {7'd0, active}, 8'd0);
    send_byte(BC);
    after_edge;
    lit("bc2_strobe", {7'd0, byte_strobe}, 8'd1);
    send_byte(BC);
    after_edge;
    lit("bc3_active", {7'd0, active}, 8'd0);
    send_byte(BC);
    after_edge;
    lit("bc4_active", {7'd0, active}, 8'd1);
    lit("bc4_valid", {7'd0, valid_out}, 8'd0);
    lit("model_act", {7'd0, m_act}, 8'd1);
    send_byte(8'h55);
    after_edge;
    lit("p55_valid", {7'd0, valid_out}, 8'd1);
    lit("p55_data", data_out, 8'h55);
    lit("model_dout", m_dout, 8'h55);

    send_byte(ID);
    after_edge;
    lit("idle_valid", {7'd0, valid_out}, 8'd0);
    lit("idle_strobe", {7'd0, byte_strobe}, 8'd1);
    send_byte(8'hA3);
    after_edge;
    lit("a3_valid", {7'd0, valid_out}, 8'd1);
    lit("a3_data", data_out, 8'hA3);
    send_byte(ID);
    after_edge;
    lit("idle2_data", data_out, 8'hA3);
    send_byte(BC);
    after_edge;
    lit("comma_valid", {7'd0, valid_out}, 8'd0);
    lit("comma_data", data_out, 8'hA3);
    send_byte(8'h01);
    after_edge;
    lit("p01_valid", {7'd0, valid_out}, 8'd1);
    lit("p01_data", data_out, 8'h01);

    drive(1'b1, 1'b1);
    drive(1'b1, 1'b0);
    drive(1'b1, 1'b1);
    drive(1'b0, 1'b1);
    after_edge;
    lit("mid_dout", data_out, 8'h00);
    lit("mid_aligned", {7'd0, aligned}, 8'd0);
    lit("mid_active", {7'd0, active}, 8'd0);
    repeat (3) send_byte(BC);
    after_edge;
    lit("re3_active", {7'd0, active}, 8'd0);
    lit("re3_aligned", {7'd0, aligned}, 8'd1);
    send_byte(BC);
    after_edge;
    lit("re4_active", {7'd0, active}, 8'd1);

    drive(1'b0, 1'b0);
    send_byte(BC);
    send_byte(BC);
    send_byte(8'h12);
    after_edge;
    lit("loss_aligned", {7'd0, aligned}, 8'd0);
    lit("loss_active", {7'd0, active}, 8'd0);
    lit("loss_strobe", {7'd0, byte_strobe}, 8'd1);
    repeat (4) send_byte(BC);
    after_edge;
    lit("relock_active", {7'd0, active}, 8'd1);

    drive(1'b0, 1'b0);
    send_byte(BC);
    send_byte(BC);
    send_byte(8'h00);
    after_edge;
    lit("shift_drop", {7'd0, aligned}, 8'd0);
    repeat (3) drive(1'b1, 1'b0);
    send_byte(BC);
    after_edge;
    lit("shift_lock", {7'd0, aligned}, 8'd1);
    lit("shift_nostb", {7'd0, byte_strobe}, 8'd0);
    send_byte(BC);
    after_edge;
    lit("shift_stb", {7'd0, byte_strobe}, 8'd1);
    lit("shift_act", {7'd0, active}, 8'd0);

    repeat (4) drive(1'b1, 1'b0);
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
